// File: rtl/ula_sequencer.sv
// ula_sequencer: issues one operation at a time onto the shared result bus.
// It registers the operands and enables a single functional unit for SETTLE
// cycles. It then captures the bus into res_data and offers it downstream
// with a valid/ready handshake. Flags track the last comparison result.
module ula_sequencer #(
    parameter int WIDTH   = 8,
    parameter int N_UNITS = 4,
    parameter int SETTLE  = 1,
    parameter int CMP_IDX = 3,
    localparam int SELW   = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [SELW-1:0]    op_sel,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    output logic [N_UNITS-1:0] en,
    input  logic [WIDTH:0]     bus_in,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH:0]     res_data,
    output logic               err,
    output logic               flag_gt,
    output logic               flag_lt,
    output logic               flag_eq
);

    localparam logic [3:0]      SETTLE_M1 = 4'(SETTLE - 1);
    localparam logic [SELW-1:0] CMP_SEL   = SELW'(CMP_IDX);
    localparam bit              CMP_OK    = (CMP_IDX >= 0) && (CMP_IDX < N_UNITS);

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    state_t          state;
    state_t          state_nx;
    logic [3:0]      cnt;
    logic [SELW-1:0] sel_q;
    logic            accept;
    logic            sel_ok;
    logic            capture;

    // Handshake decode, capture strobe and next-state selection
    always_comb begin
        in_ready = (state == IDLE);
        accept   = in_valid && (state == IDLE);
        sel_ok   = (32'(op_sel) < 32'(N_UNITS));
        capture  = (state == DRIVE) && (cnt == SETTLE_M1);
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = sel_ok ? DRIVE : HOLD;
            DRIVE:   if (capture) state_nx = HOLD;
            HOLD:    if (res_valid && res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Operand, enable, result and flag registers.
    // The error path enters HOLD at acceptance but raises res_valid one
    // edge later, so both paths present a result no earlier than edge k+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out     <= '0;
            b_out     <= '0;
            en        <= '0;
            cnt       <= '0;
            sel_q     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            err       <= 1'b0;
            flag_gt   <= 1'b0;
            flag_lt   <= 1'b0;
            flag_eq   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_out <= op_a;
                        b_out <= op_b;
                        sel_q <= op_sel;
                        cnt   <= '0;
                        if (sel_ok) begin
                            en <= N_UNITS'(1) << op_sel;
                        end else begin
                            res_data <= '0;
                            err      <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    cnt <= cnt + 4'd1;
                    if (capture) begin
                        res_data  <= bus_in;
                        err       <= 1'b0;
                        en        <= '0;
                        res_valid <= 1'b1;
                        if (CMP_OK && (sel_q == CMP_SEL)) begin
                            flag_gt <= bus_in[3];
                            flag_lt <= bus_in[4];
                            flag_eq <= bus_in[7];
                        end
                    end
                end
                HOLD: begin
                    if (!res_valid)     res_valid <= 1'b1;
                    else if (res_ready) res_valid <= 1'b0;
                end
                default: begin
                    en <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_sequencer.sv
// Directed bench for ula_sequencer: instance A (4 units, SETTLE=1, compare
// unit 3) and instance B (3 units, SETTLE=3) exercising the error path.
module tb_ula_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Instance A signals
    logic       a_in_valid, a_in_ready, a_res_valid, a_res_ready, a_err;
    logic [7:0] a_op_a, a_op_b, a_a_out, a_b_out;
    logic [1:0] a_op_sel;
    logic [3:0] a_en;
    logic [8:0] a_bus, a_res_data;
    logic       a_gt, a_lt, a_eq;

    // Instance B signals
    logic       b_in_valid, b_in_ready, b_res_valid, b_res_ready, b_err;
    logic [7:0] b_op_a, b_op_b, b_a_out, b_b_out;
    logic [1:0] b_op_sel;
    logic [2:0] b_en;
    logic [8:0] b_bus, b_res_data;
    logic       b_gt, b_lt, b_eq;

    ula_sequencer #(.WIDTH(8), .N_UNITS(4), .SETTLE(1), .CMP_IDX(3)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .op_a(a_op_a), .op_b(a_op_b), .op_sel(a_op_sel),
        .a_out(a_a_out), .b_out(a_b_out), .en(a_en), .bus_in(a_bus),
        .res_valid(a_res_valid), .res_ready(a_res_ready), .res_data(a_res_data),
        .err(a_err), .flag_gt(a_gt), .flag_lt(a_lt), .flag_eq(a_eq)
    );

    ula_sequencer #(.WIDTH(8), .N_UNITS(3), .SETTLE(3), .CMP_IDX(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .op_a(b_op_a), .op_b(b_op_b), .op_sel(b_op_sel),
        .a_out(b_a_out), .b_out(b_b_out), .en(b_en), .bus_in(b_bus),
        .res_valid(b_res_valid), .res_ready(b_res_ready), .res_data(b_res_data),
        .err(b_err), .flag_gt(b_gt), .flag_lt(b_lt), .flag_eq(b_eq)
    );

    // Bus models: unit 3 compares (gt=3, lt=4, ge=5, le=6, eq=7), unit 1 returns
    // a constant; an undriven bus reads as all ones.
    always_comb begin
        a_bus = 9'h1FF;
        if (a_en[3])
            a_bus = {1'b0, a_a_out == a_b_out, a_a_out <= a_b_out, a_a_out >= a_b_out,
                     a_a_out < a_b_out, a_a_out > a_b_out, 3'b000};
        else if (a_en[1])
            a_bus = 9'h1AB;
    end

    always_comb begin
        b_bus = 9'h1FF;
        if (b_en[1]) b_bus = {1'b0, b_a_out ^ b_b_out};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_op_a = 0; a_op_b = 0; a_op_sel = 0; a_res_ready = 1;
        b_in_valid = 0; b_op_a = 0; b_op_b = 0; b_op_sel = 0; b_res_ready = 0;
        #2;
        check("rst_in_ready", 32'(a_in_ready), 1);
        check("rst_en", 32'(a_en), 0);
        check("rst_res_valid", 32'(a_res_valid), 0);
        check("rst_res_data", 32'(a_res_data), 0);
        check("rst_flags", {29'd0, a_gt, a_lt, a_eq}, 0);
        check("rst_a_out", 32'(a_a_out), 0);
        check("rst_b_in_ready", 32'(b_in_ready), 1);
        tick(); tick();
        rst = 1'b0;

        // Compare 0x20 vs 0x10
        a_in_valid = 1; a_op_sel = 3; a_op_a = 8'h20; a_op_b = 8'h10;
        tick();
        check("gt_en", 32'(a_en), 32'h8);
        check("gt_in_ready", 32'(a_in_ready), 0);
        check("gt_valid_early", 32'(a_res_valid), 0);
        a_in_valid = 0; a_op_a = 8'hFF;
        tick();
        check("gt_en_off", 32'(a_en), 0);
        check("gt_valid", 32'(a_res_valid), 1);
        check("gt_data", 32'(a_res_data), 32'h028);
        check("gt_flags", {29'd0, a_gt, a_lt, a_eq}, 32'b100);
        check("gt_err", 32'(a_err), 0);
        check("gt_a_held", 32'(a_a_out), 32'h20);
        tick();
        check("gt_release", 32'(a_res_valid), 0);
        check("gt_idle", 32'(a_in_ready), 1);

        // Compare equal operands
        a_in_valid = 1; a_op_sel = 3; a_op_a = 8'h55; a_op_b = 8'h55;
        tick();
        check("eq_en", 32'(a_en), 32'h8);
        a_in_valid = 0;
        tick();
        check("eq_data", 32'(a_res_data), 32'h0E0);
        check("eq_flags", {29'd0, a_gt, a_lt, a_eq}, 32'b001);
        tick();

        // Non-compare unit leaves flags alone
        a_in_valid = 1; a_op_sel = 1; a_op_a = 8'h01; a_op_b = 8'h02;
        tick();
        check("u1_en", 32'(a_en), 32'h2);
        a_in_valid = 0;
        tick();
        check("u1_data", 32'(a_res_data), 32'h1AB);
        check("u1_flags", {29'd0, a_gt, a_lt, a_eq}, 32'b001);
        tick();

        // Reset while driving
        a_in_valid = 1; a_op_sel = 3; a_op_a = 8'h30; a_op_b = 8'h30;
        tick();
        check("mid_en_on", 32'(a_en), 32'h8);
        #1 rst = 1'b1;
        #1;
        check("mid_en_drop", 32'(a_en), 0);
        check("mid_in_ready", 32'(a_in_ready), 1);
        check("mid_flags", {29'd0, a_gt, a_lt, a_eq}, 0);
        #1 rst = 1'b0;
        a_in_valid = 0;
        tick();
        check("mid_no_result", 32'(a_res_valid), 0);
        check("mid_idle", 32'(a_in_ready), 1);
        check("mid_en_idle", 32'(a_en), 0);

        // Instance B: out-of-range unit
        b_in_valid = 1; b_op_sel = 3; b_op_a = 8'h12; b_op_b = 8'h34;
        tick();
        check("err_en", 32'(b_en), 0);
        check("err_in_ready", 32'(b_in_ready), 0);
        check("err_valid_early", 32'(b_res_valid), 0);
        b_op_sel = 1; b_op_a = 8'h0F; b_op_b = 8'hF0;
        tick();
        check("err_valid", 32'(b_res_valid), 1);
        check("err_flag", 32'(b_err), 1);
        check("err_data", 32'(b_res_data), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(b_res_valid), 1);
            check("stall_data", 32'(b_res_data), 0);
            check("stall_in_ready", 32'(b_in_ready), 0);
            check("stall_en", 32'(b_en), 0);
            check("stall_a_out", 32'(b_a_out), 32'h12);
        end
        b_res_ready = 1;
        tick();
        check("drain_valid", 32'(b_res_valid), 0);
        check("drain_idle", 32'(b_in_ready), 1);
        tick();
        check("s3_en_c0", 32'(b_en), 32'h2);
        check("s3_a_out", 32'(b_a_out), 32'h0F);
        b_in_valid = 0;
        tick();
        check("s3_en_c1", 32'(b_en), 32'h2);
        tick();
        check("s3_en_c2", 32'(b_en), 32'h2);
        check("s3_valid_early", 32'(b_res_valid), 0);
        tick();
        check("s3_en_off", 32'(b_en), 0);
        check("s3_valid", 32'(b_res_valid), 1);
        check("s3_data", 32'(b_res_data), 32'h0FF);
        check("s3_err", 32'(b_err), 0);
        check("s3_flags", {29'd0, b_gt, b_lt, b_eq}, 0);
        tick();
        check("s3_release", 32'(b_res_valid), 0);
        check("s3_idle", 32'(b_in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
